// File: rtl/piso_serializer_sync_res.sv
// ---------------------------------------------------------------------------
// piso_serializer_sync_res
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is accepted on a
// valid/ready handshake and sent one bit per clock on ser_out, qualified by
// ser_valid. The first bit appears one cycle after acceptance, together with
// a frame_start pulse. A new word can be accepted during the final bit of
// the current word, so back-to-back words stream with no idle cycle.
//
// Optional feature (compile-time macro SERIALIZER_PARITY_EN):
//   When defined, the even-parity bit of each word is sent in one extra PAR
//   cycle after the last data bit. A word then takes WIDTH+1 cycles.
//
// Parameters:
//   WIDTH      data word width in bits (2 or more)
//   MSB_FIRST  1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   load_valid   upstream word available
//   load_ready   block can accept a word this cycle (combinational)
//   load_data    word to serialize, sampled only on handshake
//   ser_out      serial data bit (registered)
//   ser_valid    ser_out carries a valid bit (registered)
//   frame_start  high with the first bit of each word (registered)
//   busy         a word is in flight
// ---------------------------------------------------------------------------
module piso_serializer_sync_res #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIALIZER_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             last_cycle;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shift_next;

  // The bit on ser_out this cycle is the last one of the current word.
`ifdef SERIALIZER_PARITY_EN
  assign last_cycle = (state_q == PAR);
`else
  assign last_cycle = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif

  assign load_ready  = !reset && ((state_q == IDLE) || last_cycle);
  assign accept      = load_valid && load_ready;
  assign busy        = (state_q != IDLE);
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;

  // ser_out is registered, so the register must be loaded with the bit that
  // goes out next cycle: the first bit straight from load_data on accept,
  // otherwise the bit adjacent to the one currently on the wire.
  assign first_bit  = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
  assign next_bit   = (MSB_FIRST != 0) ? shift_q[WIDTH-2]   : shift_q[1];
  assign shift_next = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d      = parity_q;
`endif

    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d       = cnt_q + 1'b1;
          shift_d     = shift_next;
          ser_out_d   = next_bit;
          ser_valid_d = 1'b1;
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d     = PAR;
          ser_out_d   = parity_q;
          ser_valid_d = 1'b1;
`else
          state_d     = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PAR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // A handshake overrides the end-of-word return to IDLE, which is what
    // makes back-to-back words contiguous.
    if (accept) begin
      state_d       = SHIFT;
      shift_d       = load_data;
      cnt_d         = '0;
      ser_out_d     = first_bit;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d      = ^load_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the data shift register is reset as well, so an aborted word
      // leaves no stale bits behind.
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer_sync_res.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer_sync_res
//
// Drives two WIDTH=8 serializers (MSB-first and LSB-first) from the same
// inputs and checks both against hand-written bit sequences. Inputs change
// and outputs are sampled on the falling clock edge. The parity cycle is
// checked when SERIALIZER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_piso_serializer_sync_res;

`ifdef SERIALIZER_PARITY_EN
  localparam int WLEN = 9;
`else
  localparam int WLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;

  logic load_ready_m, ser_out_m, ser_valid_m, frame_start_m, busy_m;
  logic load_ready_l, ser_out_l, ser_valid_l, frame_start_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer_sync_res #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready_m),
    .load_data   (load_data),
    .ser_out     (ser_out_m),
    .ser_valid   (ser_valid_m),
    .frame_start (frame_start_m),
    .busy        (busy_m)
  );

  piso_serializer_sync_res #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready_l),
    .load_data   (load_data),
    .ser_out     (ser_out_l),
    .ser_valid   (ser_valid_l),
    .frame_start (frame_start_l),
    .busy        (busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one full clock; returns on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Both instances idle with all registered outputs low.
  task automatic check_idle(input string tag);
    check({tag, " valid_m"}, ser_valid_m,   1'b0);
    check({tag, " valid_l"}, ser_valid_l,   1'b0);
    check({tag, " out_m"},   ser_out_m,     1'b0);
    check({tag, " out_l"},   ser_out_l,     1'b0);
    check({tag, " fs_m"},    frame_start_m, 1'b0);
    check({tag, " fs_l"},    frame_start_l, 1'b0);
    check({tag, " busy_m"},  busy_m,        1'b0);
    check({tag, " busy_l"},  busy_l,        1'b0);
  endtask

  // Send one word from IDLE. seq_m / seq_l list the expected serial bits in
  // transmit order (leftmost bit first); par is the expected parity bit.
  task automatic run_word(input string tag, input logic [7:0] d,
                          input logic [7:0] seq_m, input logic [7:0] seq_l,
                          input logic par);
    load_valid = 1'b1;
    load_data  = d;
    #1;
    check({tag, " ready_m before"}, load_ready_m, 1'b1);
    check({tag, " ready_l before"}, load_ready_l, 1'b1);
    tick();
    load_valid = 1'b0;
    load_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("%s bit%0d valid", tag, i), ser_valid_m & ser_valid_l, 1'b1);
      check($sformatf("%s bit%0d out_m", tag, i), ser_out_m, seq_m[7-i]);
      check($sformatf("%s bit%0d out_l", tag, i), ser_out_l, seq_l[7-i]);
      check($sformatf("%s bit%0d fs", tag, i), frame_start_m, (i == 0));
      check($sformatf("%s bit%0d busy", tag, i), busy_m, 1'b1);
      check($sformatf("%s bit%0d ready", tag, i), load_ready_m, (i == WLEN - 1));
      tick();
    end
`ifdef SERIALIZER_PARITY_EN
    #1;
    check({tag, " par valid"}, ser_valid_m & ser_valid_l, 1'b1);
    check({tag, " par out_m"}, ser_out_m, par);
    check({tag, " par out_l"}, ser_out_l, par);
    check({tag, " par fs"},    frame_start_m | frame_start_l, 1'b0);
    check({tag, " par ready"}, load_ready_m & load_ready_l, 1'b1);
    tick();
`else
    check({tag, " par unused"}, {31'd0, par}, {31'd0, ^d});
`endif
    check_idle({tag, " after"});
  endtask

  initial begin
    logic [7:0] w;
    int         j;

    // Reset held for two edges while load_valid is asserted.
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    tick();
    tick();
    check_idle("reset");
    check("reset ready_m", load_ready_m, 1'b0);
    check("reset ready_l", load_ready_l, 1'b0);
    reset      = 1'b0;
    load_valid = 1'b0;
    #1;
    check("release ready_m", load_ready_m, 1'b1);
    check("release ready_l", load_ready_l, 1'b1);
    tick();
    check_idle("idle");

    // 0xA5: 10100101 both directions; even parity 0.
    run_word("a5", 8'hA5, 8'b1010_0101, 8'b1010_0101, 1'b0);
    // 0x01: MSB-first 00000001, LSB-first 10000000; parity 1.
    run_word("01", 8'h01, 8'b0000_0001, 8'b1000_0000, 1'b1);
    // 0x07: MSB-first 00000111, LSB-first 11100000; parity 1.
    run_word("07", 8'h07, 8'b0000_0111, 8'b1110_0000, 1'b1);

    // Back-to-back 0xF0 then 0x0F with load_valid held high.
    load_valid = 1'b1;
    load_data  = 8'hF0;
    tick();
    load_data  = 8'h0F;
    for (int i = 0; i < 2 * WLEN; i++) begin
      #1;
      w = (i < WLEN) ? 8'hF0 : 8'h0F;
      j = i % WLEN;
      check($sformatf("b2b c%0d valid", i), ser_valid_m & ser_valid_l, 1'b1);
      check($sformatf("b2b c%0d out_m", i), ser_out_m, (j == 8) ? 1'b0 : w[7-j]);
      check($sformatf("b2b c%0d out_l", i), ser_out_l, (j == 8) ? 1'b0 : w[j]);
      check($sformatf("b2b c%0d fs", i), frame_start_m, (j == 0));
      check($sformatf("b2b c%0d ready", i), load_ready_m, (j == WLEN - 1));
      tick();
      if (i == WLEN - 1) load_valid = 1'b0;
    end
    check_idle("b2b after");

    // Reset mid-word after three bits of 0xFF.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    check("abort bit3 out_m", ser_out_m, 1'b1);
    check("abort bit3 busy",  busy_m,    1'b1);
    reset = 1'b1;
    #1;
    check("abort ready in reset", load_ready_m | load_ready_l, 1'b0);
    tick();
    reset = 1'b0;
    check_idle("abort");
    tick();
    check_idle("abort idle");

    // 0x81 transmits cleanly after the abort: 10000001 both directions.
    run_word("81", 8'h81, 8'b1000_0001, 8'b1000_0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
